// File: rtl/nec_prefetch.sv
// Instruction prefetch queue: fetches 16-bit words into an 8-byte circular queue
// ahead of the decoder, with redirect (set_pc) and in-flight request discard.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | no bus request outstanding; start one when the queue has room
// S_FETCH   | request outstanding, returned data goes into the queue
// S_DISCARD | request outstanding after a redirect, returned data is dropped
module nec_prefetch (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ce_1,
    input  logic             ce_2,
    input  logic             set_pc,
    input  logic [15:0]      new_pc,
    input  logic [15:0]      new_ps,
    input  logic [15:0]      decode_pc,
    output logic             mem_req,
    output logic [19:0]      mem_addr,
    input  logic             mem_ack,
    input  logic [15:0]      mem_data,
    output logic [7:0][7:0]  ipq,
    output logic [3:0]       ipq_len
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FETCH   = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t           state_q;
    logic             mem_req_q;
    logic [19:0]      mem_addr_q;
    logic [15:0]      fetch_pc_q;
    logic [15:0]      ps_q;
    logic [7:0][7:0]  ipq_q;

    logic             enable;
    logic             can_fetch;
    logic [19:0]      mem_addr_d;
    logic [2:0]       wr_idx;
    logic [2:0]       wr_idx_next;
    logic             unused_decode_hi;

    // Only the low nibble of the distance matters; it is at most 8 when valid.
    assign ipq_len   = fetch_pc_q[3:0] - decode_pc[3:0];
    assign unused_decode_hi = ^decode_pc[15:4];

    assign enable      = ce_1 | ce_2;
    assign can_fetch   = fetch_pc_q[0] ? (ipq_len <= 4'd7) : (ipq_len <= 4'd6);
    assign mem_addr_d  = {ps_q, 4'h0} + {4'h0, fetch_pc_q[15:1], 1'b0};
    assign wr_idx      = fetch_pc_q[2:0];
    assign wr_idx_next = wr_idx + 3'd1;

    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
    assign ipq      = ipq_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= 20'h0_0000;
            fetch_pc_q <= 16'h0000;
            ps_q       <= 16'hFFFF;
            ipq_q      <= '0;
        end else if (enable) begin
            case (state_q)
                S_IDLE: begin
                    if (set_pc) begin
                        fetch_pc_q <= new_pc;
                        ps_q       <= new_ps;
                    end else if (can_fetch) begin
                        state_q    <= S_FETCH;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= mem_addr_d;
                    end
                end
                S_FETCH: begin
                    if (set_pc) begin
                        fetch_pc_q <= new_pc;
                        ps_q       <= new_ps;
                        if (mem_ack) begin
                            state_q   <= S_IDLE;
                            mem_req_q <= 1'b0;
                        end else begin
                            state_q   <= S_DISCARD;
                        end
                    end else if (mem_ack) begin
                        // An odd fetch_pc only needs the upper (odd) byte of the word.
                        if (fetch_pc_q[0]) begin
                            ipq_q[wr_idx] <= mem_data[15:8];
                            fetch_pc_q    <= fetch_pc_q + 16'd1;
                        end else begin
                            ipq_q[wr_idx]      <= mem_data[7:0];
                            ipq_q[wr_idx_next] <= mem_data[15:8];
                            fetch_pc_q         <= fetch_pc_q + 16'd2;
                        end
                        state_q   <= S_IDLE;
                        mem_req_q <= 1'b0;
                    end
                end
                S_DISCARD: begin
                    if (set_pc) begin
                        fetch_pc_q <= new_pc;
                        ps_q       <= new_ps;
                    end
                    if (mem_ack) begin
                        state_q   <= S_IDLE;
                        mem_req_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
